// File: rtl/instr_fetch_issue.sv
// Instruction fetch and issue stage.
// Reads 32-bit words from a one-cycle-latency instruction memory into a small
// prefetch FIFO and presents the head entry's opcode/register/function fields
// to the control decoder. A halt word (opcode 6'h3F) stops fetching. The FIFO
// then drains and the block parks in HALT until reset.
module instr_fetch_issue #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [5:0]    opcode,
  output logic [5:0]    fn_code,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [2:0]    fifo_count,
  output logic          halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          inflight_q;
  logic [2:0]    count_q, count_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   fifo_mem [DEPTH];

  logic          capture;
  logic          halt_word;
  logic          push;
  logic          pop;
  logic [3:0]    occupancy;
  logic [31:0]   head;
  logic          unused_shamt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Read data arrives one cycle after the strobe. A return that lands while
  // draining is the speculative read issued alongside the halt word, so it is dropped.
  assign capture   = inflight_q && ((state_q == IDLE) || (state_q == FETCH));
  assign halt_word = (imem_rdata[31:26] == 6'h3F);
  assign push      = capture && !halt_word;
  assign pop       = issue_valid && issue_ready;

  // Entries already held plus the one still on its way must leave room.
  // This guarantees a returning word always has a free slot.
  assign occupancy = {1'b0, count_q} + {3'b000, inflight_q};
  assign imem_rd   = (state_q == FETCH) && (occupancy < 4'(DEPTH));
  assign imem_addr = pc_q;

  assign issue_valid = (count_q != 3'd0);
  assign fifo_count  = count_q;
  assign halted      = (state_q == HALT);

  // The decode fields are forced to zero when nothing is on offer.
  assign head    = fifo_mem[rd_ptr_q];
  assign opcode  = issue_valid ? head[31:26] : 6'd0;
  assign rs      = issue_valid ? head[25:21] : 5'd0;
  assign rt      = issue_valid ? head[20:16] : 5'd0;
  assign rd      = issue_valid ? head[15:11] : 5'd0;
  assign fn_code = issue_valid ? head[5:0]   : 6'd0;
  // The shift-amount field is stored but never presented.
  assign unused_shamt = ^head[10:6];

  // Next-state logic: FSM, PC and FIFO occupancy.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;

    case (state_q)
      // A read issued just before en dropped can still return a halt word here.
      IDLE:    if (capture && halt_word) state_d = DRAIN;
               else if (en)              state_d = FETCH;
      FETCH:   if (capture && halt_word) state_d = DRAIN;
               else if (!en)             state_d = IDLE;
      DRAIN:   if (count_q == 3'd0)      state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (imem_rd) pc_d = pc_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // State register, PC, in-flight flag and FIFO pointers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= imem_rd;
      count_q    <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. The pointers and count define which entries are valid.
    if (push) fifo_mem[wr_ptr_q] <= imem_rdata;
  end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: table-driven decode-field vectors
// plus directed sequences for backpressure, halt, wrap, reset and en toggling.
module tb_instr_fetch_issue;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          imem_rd;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic          issue_valid;
  logic          issue_ready;
  logic [5:0]    opcode;
  logic [5:0]    fn_code;
  logic [4:0]    rs, rt, rd;
  logic [2:0]    fifo_count;
  logic          halted;

  instr_fetch_issue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .opcode      (opcode),
    .fn_code     (fn_code),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .fifo_count  (fifo_count),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory model: data valid the cycle after the strobe. A junk pattern appears otherwise.
  logic [31:0] mem [256];
  always @(posedge clk) imem_rdata <= imem_rd ? mem[imem_addr] : 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] word;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } vec_t;

  vec_t tbl [8];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    en          = 1'b0;
    issue_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic load_table();
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = tbl[i].word;
  endtask

  // Occupancy plus the read in flight may never exceed DEPTH. Otherwise a return could hit a full FIFO.
  logic tb_inflight = 1'b0;
  always @(posedge clk) tb_inflight <= (reset === 1'b1) ? 1'b0 : imem_rd;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("no_push_when_full",
            32'((({1'b0, fifo_count} + {3'b000, tb_inflight}) <= 4'(DEPTH))), 32'd1);
      check("valid_tracks_count", 32'(issue_valid), 32'(fifo_count != 3'd0));
    end
  end

  initial begin
    int  nrd;
    bit  found;

    // Hand-decoded vectors: word, opcode, fn_code, rs, rt, rd.
    tbl[0] = '{32'h00221820, 6'h00, 6'h20, 5'd1,  5'd2,  5'd3};
    tbl[1] = '{32'h00221822, 6'h00, 6'h22, 5'd1,  5'd2,  5'd3};
    tbl[2] = '{32'h8C010004, 6'h23, 6'h04, 5'd0,  5'd1,  5'd0};
    tbl[3] = '{32'h00000000, 6'h00, 6'h00, 5'd0,  5'd0,  5'd0};
    tbl[4] = '{32'h014B4825, 6'h00, 6'h25, 5'd10, 5'd11, 5'd9};
    tbl[5] = '{32'hAFBF0010, 6'h2B, 6'h10, 5'd29, 5'd31, 5'd0};
    tbl[6] = '{32'h3C08FFFF, 6'h0F, 6'h3F, 5'd0,  5'd8,  5'd31};
    tbl[7] = '{32'hF8000000, 6'h3E, 6'h00, 5'd0,  5'd0,  5'd0};
    load_table();

    // ---------------- reset state ----------------
    do_reset();
    check("rst_count",  32'(fifo_count),  32'd0);
    check("rst_valid",  32'(issue_valid), 32'd0);
    check("rst_rd",     32'(imem_rd),     32'd0);
    check("rst_addr",   32'(imem_addr),   32'd0);
    check("rst_halted", 32'(halted),      32'd0);
    check("rst_fields", {opcode, fn_code, rs, rt, rd, 5'd0}, 32'd0);

    // issue_ready with an empty FIFO must not underflow
    issue_ready = 1'b1;
    step();
    step();
    check("ready_when_empty_count", 32'(fifo_count), 32'd0);

    // ---------------- streaming, table-driven ----------------
    en = 1'b1;
    step();
    check("stream_first_rd",   32'(imem_rd),   32'd1);
    check("stream_first_addr", 32'(imem_addr), 32'd0);
    step();
    check("stream_valid_n1", 32'(issue_valid), 32'd0);
    step();
    check("stream_valid_n2", 32'(issue_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("vec%0d_valid", i), 32'(issue_valid), 32'd1);
      check($sformatf("vec%0d_opcode", i), 32'(opcode),  32'(tbl[i].op));
      check($sformatf("vec%0d_fn", i),     32'(fn_code), 32'(tbl[i].fn));
      check($sformatf("vec%0d_rs", i),     32'(rs),      32'(tbl[i].rs));
      check($sformatf("vec%0d_rt", i),     32'(rt),      32'(tbl[i].rt));
      check($sformatf("vec%0d_rd", i),     32'(rd),      32'(tbl[i].rd));
      step();
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("stream_drained", 32'(fifo_count), 32'd0);

    // ---------------- backpressure ----------------
    do_reset();
    en  = 1'b1;
    nrd = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_rd) nrd++;
    end
    check("bp_reads",   32'(nrd),        32'd4);
    check("bp_count",   32'(fifo_count), 32'd4);
    check("bp_pc",      32'(imem_addr),  32'd4);
    check("bp_rd_held", 32'(imem_rd),    32'd0);
    issue_ready = 1'b1;
    check("bp_pop0_fn", 32'(fn_code), 32'(tbl[0].fn));
    step();
    check("bp_resume_rd",   32'(imem_rd),   32'd1);
    check("bp_resume_addr", 32'(imem_addr), 32'd4);
    check("bp_pop1_fn",     32'(fn_code),   32'(tbl[1].fn));
    step();
    check("bp_pop2_op", 32'(opcode),  32'(tbl[2].op));
    check("bp_pop2_fn", 32'(fn_code), 32'(tbl[2].fn));
    step();
    check("bp_pop3_fn",    32'(fn_code),     32'(tbl[3].fn));
    check("bp_pop3_valid", 32'(issue_valid), 32'd1);
    step();
    check("bp_next_fn", 32'(fn_code), 32'(tbl[4].fn));

    // ---------------- halt ----------------
    do_reset();
    clear_mem();
    mem[0] = 32'h00221820;
    mem[1] = 32'h00221822;
    mem[2] = 32'hFC000000;
    mem[3] = 32'h8C010004;
    en          = 1'b1;
    issue_ready = 1'b1;
    step();
    step();
    step();
    check("halt_a0_valid", 32'(issue_valid), 32'd1);
    check("halt_a0_fn",    32'(fn_code),     32'h20);
    step();
    check("halt_a1_fn",    32'(fn_code),     32'h22);
    check("halt_spec_rd",  32'(imem_rd),     32'd1);
    check("halt_spec_addr", 32'(imem_addr),  32'd3);
    check("halt_a1_halted", 32'(halted),     32'd0);
    step();
    check("halt_drain_valid",  32'(issue_valid), 32'd0);
    check("halt_drain_rd",     32'(imem_rd),     32'd0);
    check("halt_drain_halted", 32'(halted),      32'd0);
    step();
    check("halt_halted",  32'(halted),      32'd1);
    check("halt_count",   32'(fifo_count),  32'd0);
    check("halt_valid",   32'(issue_valid), 32'd0);
    check("halt_opcode",  32'(opcode),      32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("halt_hold_rd",     32'(imem_rd),    32'd0);
      check("halt_hold_halted", 32'(halted),     32'd1);
      check("halt_hold_count",  32'(fifo_count), 32'd0);
    end

    // ---------------- PC wrap ----------------
    do_reset();
    clear_mem();
    en          = 1'b1;
    issue_ready = 1'b1;
    found       = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      if (imem_rd && imem_addr == 8'hFE) begin
        found = 1'b1;
        break;
      end
    end
    check("wrap_reach_fe", 32'(found), 32'd1);
    step();
    check("wrap_ff_rd",   32'(imem_rd),   32'd1);
    check("wrap_ff_addr", 32'(imem_addr), 32'hFF);
    step();
    check("wrap_00_rd",   32'(imem_rd),   32'd1);
    check("wrap_00_addr", 32'(imem_addr), 32'h00);

    // ---------------- reset mid-stream ----------------
    do_reset();
    load_table();
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("mid_rd_before", 32'(imem_rd), 32'd1);
    step();
    check("mid_count_before", 32'(fifo_count), 32'd3);
    reset = 1'b1;
    step();
    check("mid_count",  32'(fifo_count),  32'd0);
    check("mid_valid",  32'(issue_valid), 32'd0);
    check("mid_addr",   32'(imem_addr),   32'd0);
    check("mid_halted", 32'(halted),      32'd0);
    check("mid_rd",     32'(imem_rd),     32'd0);
    check("mid_fields", {opcode, fn_code, rs, rt, rd, 5'd0}, 32'd0);
    reset = 1'b0;
    en    = 1'b0;
    step();
    check("mid_no_push", 32'(fifo_count), 32'd0);
    step();
    check("mid_still_empty", 32'(fifo_count), 32'd0);

    // ---------------- en toggle ----------------
    do_reset();
    en          = 1'b1;
    issue_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("tog_rd5",   32'(imem_rd),   32'd1);
    check("tog_addr5", 32'(imem_addr), 32'd5);
    en = 1'b0;
    step();
    check("tog_rd_off", 32'(imem_rd), 32'd0);
    step();
    check("tog_a5_valid", 32'(issue_valid), 32'd1);
    check("tog_a5_op",    32'(opcode),      32'(tbl[5].op));
    check("tog_a5_fn",    32'(fn_code),     32'(tbl[5].fn));
    check("tog_pc6",      32'(imem_addr),   32'd6);
    check("tog_rd_off2",  32'(imem_rd),     32'd0);
    step();
    check("tog_empty",   32'(issue_valid), 32'd0);
    check("tog_rd_off3", 32'(imem_rd),     32'd0);
    step();
    en = 1'b1;
    step();
    check("tog_resume_rd",   32'(imem_rd),   32'd1);
    check("tog_resume_addr", 32'(imem_addr), 32'd6);

    en          = 1'b0;
    issue_ready = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_issue.md
INSTR_FETCH_ISSUE -- requirements
Module: instr_fetch_issue

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DEPTH, 4, prefetch FIFO entries
- AW, 8, instruction memory word-address width
REQ-002 Ports SHALL be, one per line (name direction width meaning):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  fetch enable
- imem_rd  out  1  instruction memory read strobe
- imem_addr  out  AW  word address of current read
- imem_rdata  in  32  read data, valid exactly one cycle after imem_rd
- issue_valid  out  1  head instruction available to decode
- issue_ready  in  1  decode accepts head instruction
- opcode  out  6  head bits [31:26]
- fn_code  out  6  head bits [5:0]
- rs, rt, rd  out  5 each  head bits [25:21], [20:16], [15:11]
- fifo_count  out  3  FIFO occupancy, 0..DEPTH
- halted  out  1  halt instruction reached and FIFO drained
REQ-003 The block SHALL have one clock (clk) and a synchronous, active-high reset (reset); no other clock or asynchronous reset SHALL exist.

Function
REQ-004 The block SHALL be the issuing end of the decode interface: it fetches 32-bit words and presents their opcode/fn_code/register fields to the control decoder.
REQ-005 FSM states SHALL be IDLE, FETCH, DRAIN, HALT.
REQ-006 IDLE -> FETCH when en=1; FETCH -> IDLE when en=0; FETCH -> DRAIN on capture of a halt word; DRAIN -> HALT when fifo_count=0; HALT persists until reset.
REQ-007 Halt word SHALL be any word with bits [31:26]=6'h3F.
REQ-008 imem_rd SHALL be 1 only in FETCH, and only when fifo_count + inflight < DEPTH, where inflight=1 if imem_rd was 1 in the previous cycle.
REQ-009 imem_addr SHALL equal the PC; PC increments by 1 in each cycle where imem_rd=1, wrapping from 2^AW-1 to 0.
REQ-010 Data returned one cycle after imem_rd=1 SHALL be pushed into the FIFO, including data for reads issued in a cycle where en then drops.
REQ-011 A halt word SHALL NOT be pushed.
REQ-012 Data returned in the cycle after the halt word is captured (a speculative read) SHALL be discarded.
REQ-013 issue_valid SHALL equal (fifo_count != 0).
REQ-014 opcode/fn_code/rs/rt/rd SHALL be the FIFO head fields when issue_valid=1, and all zero otherwise.
REQ-015 Pop SHALL occur when issue_valid and issue_ready are both 1; the next entry, if any, SHALL appear the following cycle.
REQ-016 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-017 Push with the FIFO full SHALL be impossible by construction (REQ-008); the bench asserts it never occurs.
REQ-018 Latency: a word read in cycle N SHALL be presented with issue_valid=1 at cycle N+2 when the FIFO was empty.
REQ-019 halted SHALL be 1 exactly in HALT.
REQ-020 issue_ready SHALL be ignored when issue_valid=0.

Reset
REQ-021 In any cycle with reset=1, state SHALL become IDLE, PC=0, FIFO empty (fifo_count=0), inflight cleared, halted=0, imem_rd=0, issue_valid=0 and all field outputs 0 on the next edge.
REQ-022 Reset mid-operation SHALL discard any in-flight read data; no push occurs in the cycle after reset.

Verification
REQ-023 Streaming: mem[0..3]=0x00221820, 0x00221822, 0x8C010004, 0x00000000; en=1, issue_ready=1 -> opcode/fn_code pairs 00/20, 00/22, 23/04, 00/00 issued in order; first issue_valid at cycle 2 after en.
REQ-024 Backpressure: issue_ready=0 for 10 cycles -> imem_rd stops once fifo_count+inflight=4; fifo_count=4, PC=4; releasing ready drains 4 entries in 4 cycles and fetch resumes at addr 4.
REQ-025 Halt: mem[2]=0xFC000000 -> entries from addr 0 and 1 issued, halt word not issued, data at addr 3 discarded, halted=1 one cycle after last pop; imem_rd stays 0 thereafter.
REQ-026 Wrap: with PC preloaded to 0xFE by fetching from reset, AW=8 -> addresses 0xFE, 0xFF, 0x00 appear on imem_addr consecutively.
REQ-027 Reset mid-stream: assert reset with fifo_count=3 and a read in flight -> next cycle fifo_count=0, issue_valid=0, imem_addr=0, halted=0, and the in-flight data is not pushed.
REQ-028 en toggle: en drops in the same cycle imem_rd=1 at addr 5 -> the addr-5 word is still pushed, no read of addr 6 until en=1 again.
